edram_writeback: RTL and testbench

//  Write-back end of the DianNao node output path. Captures the 16-lane NFU-3 result bus
//  (o_to_edram of the node) a fixed pipeline latency after each final-result issue.

---
 rtl/edram_writeback.sv | 199 +++++++++++++++++++
 tb/tb_edram_writeback.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edram_writeback.sv
// edram_writeback: write-back end of the node output path.
// A PIPE_LAT-deep delay of i_nfu3_issue marks the cycles when i_to_edram holds a
// final result. Those words are pushed into a DEPTH-entry FIFO and drained to the
// eDRAM write port at sequential addresses starting from the job's base address.
// Optional feature macro: EDRAM_WB_RELU_EN clamps negative lanes to zero at capture.
module edram_writeback #(
    parameter int N          = 16,
    parameter int TN         = 16,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int PIPE_LAT   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [CNT_WIDTH-1:0]  i_num_outputs,
    input  logic                  i_nfu3_issue,
    input  logic [N*TN-1:0]       i_to_edram,
    output logic                  o_wr_valid,
    input  logic                  i_wr_ready,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [N*TN-1:0]       o_wr_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow
);

    localparam int W  = N * TN;
    localparam int PW = $clog2(DEPTH);

    localparam logic [PW:0]           CNT_ONE   = (PW + 1)'(1);
    localparam logic [PW:0]           CNT_DEPTH = (PW + 1)'(DEPTH);
    localparam logic [PW-1:0]         PTR_ONE   = PW'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CAP_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [PIPE_LAT-1:0]   issue_dly_q;
    logic                  delayed_issue;
    logic [CNT_WIDTH-1:0]  num_q;
    logic [CNT_WIDTH-1:0]  captured_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  overflow_q;

    logic [W-1:0]          mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           count_q, count_d;
    logic                  valid_q;

    logic                  start_job;
    logic                  capture;
    logic                  fifo_full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [W-1:0]          cap_word;

    assign delayed_issue = issue_dly_q[PIPE_LAT-1];
    assign start_job     = (state_q == S_IDLE) && i_start;
    assign capture       = (state_q == S_RUN) && delayed_issue && (captured_q < num_q);
    assign fifo_full     = (count_q == CNT_DEPTH);
    assign pop           = valid_q && i_wr_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push          = capture && (!fifo_full || pop);
    assign drop          = capture && fifo_full && !pop;

`ifdef EDRAM_WB_RELU_EN
    // Clamp each negative lane to zero before it is stored.
    always_comb begin
        cap_word = i_to_edram;
        for (int l = 0; l < TN; l++) begin
            if (i_to_edram[l*N + N - 1]) begin
                cap_word[l*N +: N] = '0;
            end
        end
    end
`else
    assign cap_word = i_to_edram;
`endif

    // Issue delay line: shifts in every state so its timing never depends on the FSM.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_dly_q <= '0;
        end else begin
            issue_dly_q <= (issue_dly_q << 1) | PIPE_LAT'(i_nfu3_issue);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and status outputs.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        o_busy  = 1'b1;
        o_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_d = S_RUN;
            end
            S_RUN: begin
                if (captured_q == num_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (count_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Job bookkeeping: capture count and sticky overflow, both reset by a new job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q      <= '0;
            captured_q <= '0;
            overflow_q <= 1'b0;
        end else if (start_job) begin
            num_q      <= i_num_outputs;
            captured_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (capture) captured_q <= captured_q + CAP_ONE;
            if (drop)    overflow_q <= 1'b1;
        end
    end

    // Write address: loaded from the base, advanced only by accepted writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (start_job) begin
            addr_q <= i_base_addr;
        end else if (pop) begin
            addr_q <= addr_q + ADDR_ONE;
        end
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage.
    // NOTE: the data array is not reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= cap_word;
    end

    // FIFO pointers, occupancy and the registered write-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    assign o_wr_valid = valid_q;
    assign o_wr_addr  = addr_q;
    // Data is forced to zero while idle so stale storage never shows on the port.
    assign o_wr_data  = valid_q ? mem[rd_ptr_q] : '0;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_edram_writeback.sv
// tb_edram_writeback: table-driven jobs, hand-written corner sequences and random
// jobs, all compared every cycle against a queue-based reference model.
module tb_edram_writeback;

    localparam int N        = 16;
    localparam int TN       = 16;
    localparam int W        = N * TN;
    localparam int DEPTH    = 4;
    localparam int PIPE_LAT = 3;

    typedef logic [W-1:0] word_t;
    typedef enum int {P_IDLE, P_COLLECT, P_FLUSH, P_END} phase_t;

    typedef struct {
        logic [15:0] base;
        logic [15:0] num;
        int          n_issues;
        int          period;
        int          stall;
        int          exp_writes;
        bit          exp_ovf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [15:0] i_base_addr;
    logic [15:0] i_num_outputs;
    logic        i_nfu3_issue;
    word_t       i_to_edram;
    logic        o_wr_valid;
    logic        i_wr_ready;
    logic [15:0] o_wr_addr;
    word_t       o_wr_data;
    logic        o_busy;
    logic        o_done;
    logic        o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    phase_t      m_phase;
    word_t       m_fifo[$];
    bit          m_dq[$];
    logic [15:0] m_addr;
    logic [15:0] m_num;
    logic [15:0] m_captured;
    bit          m_ovf;

    edram_writeback dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_base_addr   (i_base_addr),
        .i_num_outputs (i_num_outputs),
        .i_nfu3_issue  (i_nfu3_issue),
        .i_to_edram    (i_to_edram),
        .o_wr_valid    (o_wr_valid),
        .i_wr_ready    (i_wr_ready),
        .o_wr_addr     (o_wr_addr),
        .o_wr_data     (o_wr_data),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_overflow    (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Word as it should land in eDRAM.
    function automatic word_t expect_word(input word_t w);
        word_t r = w;
`ifdef EDRAM_WB_RELU_EN
        for (int l = 0; l < TN; l++) begin
            shortint s;
            s = shortint'(w[l*N +: N]);
            if (s < 0) r[l*N +: N] = '0;
        end
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_phase    = P_IDLE;
        m_fifo     = {};
        m_dq       = {};
        for (int i = 0; i < PIPE_LAT; i++) m_dq.push_back(1'b0);
        m_addr     = '0;
        m_num      = '0;
        m_captured = '0;
        m_ovf      = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit          pop;
        bit          delayed;
        bit          cap;
        int          pre_size;
        logic [15:0] pre_captured;
        pre_size     = m_fifo.size();
        pre_captured = m_captured;
        pop          = (pre_size > 0) && i_wr_ready;
        delayed      = m_dq.pop_front();
        m_dq.push_back(i_nfu3_issue);
        cap = (m_phase == P_COLLECT) && delayed && (m_captured < m_num);
        if (pop) begin
            void'(m_fifo.pop_front());
            m_addr = m_addr + 16'd1;
        end
        if (cap) begin
            m_captured = m_captured + 16'd1;
            if (m_fifo.size() < DEPTH) m_fifo.push_back(expect_word(i_to_edram));
            else                       m_ovf = 1'b1;
        end
        case (m_phase)
            P_IDLE: if (i_start) begin
                m_phase    = P_COLLECT;
                m_addr     = i_base_addr;
                m_num      = i_num_outputs;
                m_captured = '0;
                m_ovf      = 1'b0;
            end
            P_COLLECT: if (pre_captured == m_num) m_phase = P_FLUSH;
            P_FLUSH:   if (pre_size == 0) m_phase = P_END;
            default:   m_phase = P_IDLE;
        endcase
    endtask

    task automatic compare_model();
        check("wr_valid", W'(o_wr_valid), W'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) check("wr_data", o_wr_data, m_fifo[0]);
        check("wr_addr", W'(o_wr_addr), W'(m_addr));
        check("busy", W'(o_busy), W'(m_phase != P_IDLE));
        check("done", W'(o_done), W'(m_phase == P_END));
        check("overflow", W'(o_overflow), W'(m_ovf));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // One job: start pulse, issues every `period` cycles, ready low for `stall`
    // cycles then high (or random). Optional second start during the job and
    // optional fixed data pattern whose first two lanes are checked on each write.
    task automatic run_job(input logic [15:0] base, input logic [15:0] num,
                           input int n_issues, input int period, input int stall,
                           input bit rand_ready, input int restart_k, input bit fixed_data,
                           output int writes, output int dones);
        int  issued = 0;
        bit  finished = 0;
        word_t fixed_w;
        for (int l = 0; l < TN; l++) fixed_w[l*N +: N] = (l % 2 == 0) ? 16'hC000 : 16'h0123;
        fixed_w[15:0]  = 16'h8001;
        fixed_w[31:16] = 16'h7FFF;
        writes = 0;
        dones  = 0;
        for (int k = 0; k < 600 && !finished; k++) begin
            i_start       = (k == 0) || (k == restart_k);
            i_base_addr   = (k == 0) ? base : ~base;
            i_num_outputs = (k == 0) ? num : num + 16'd5;
            i_nfu3_issue  = 1'b0;
            if (k >= 1 && issued < n_issues && ((k - 1) % period) == 0) begin
                i_nfu3_issue = 1'b1;
                issued++;
            end
            i_to_edram = fixed_data ? fixed_w : rand_word();
            i_wr_ready = (k < stall) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            if (o_wr_valid && i_wr_ready) begin
                writes++;
                if (fixed_data) begin
`ifdef EDRAM_WB_RELU_EN
                    check("relu_lane0", W'(o_wr_data[15:0]), W'(16'h0000));
`else
                    check("raw_lane0", W'(o_wr_data[15:0]), W'(16'h8001));
`endif
                    check("lane1", W'(o_wr_data[31:16]), W'(16'h7FFF));
                end
            end
            tick();
            if (o_done) dones++;
            if (dones > 0 && !o_busy) finished = 1;
        end
        i_start      = 1'b0;
        i_nfu3_issue = 1'b0;
        if (!finished) check("job_timeout_busy", W'(o_busy), W'(1'b0));
    endtask

    vec_t vecs[5];

    initial begin
        int writes;
        int dones;

        vecs[0] = '{base: 16'h0100, num: 16'd3, n_issues: 3, period: 1, stall: 0,  exp_writes: 3, exp_ovf: 1'b0};
        vecs[1] = '{base: 16'h0200, num: 16'd4, n_issues: 4, period: 1, stall: 20, exp_writes: 4, exp_ovf: 1'b0};
        vecs[2] = '{base: 16'h0300, num: 16'd6, n_issues: 6, period: 1, stall: 30, exp_writes: 4, exp_ovf: 1'b1};
        vecs[3] = '{base: 16'hFFFE, num: 16'd3, n_issues: 3, period: 1, stall: 0,  exp_writes: 3, exp_ovf: 1'b0};
        vecs[4] = '{base: 16'h0400, num: 16'd0, n_issues: 0, period: 1, stall: 0,  exp_writes: 0, exp_ovf: 1'b0};

        rst_n         = 1'b0;
        i_start       = 1'b0;
        i_base_addr   = '0;
        i_num_outputs = '0;
        i_nfu3_issue  = 1'b0;
        i_to_edram    = '0;
        i_wr_ready    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", W'(o_wr_valid), W'(1'b0));
        check("rst_addr", W'(o_wr_addr), W'(16'h0000));
        check("rst_data", o_wr_data, '0);
        check("rst_busy", W'(o_busy), W'(1'b0));
        check("rst_done", W'(o_done), W'(1'b0));
        check("rst_overflow", W'(o_overflow), W'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // table-driven jobs
        for (int v = 0; v < 5; v++) begin
            run_job(vecs[v].base, vecs[v].num, vecs[v].n_issues, vecs[v].period,
                    vecs[v].stall, 1'b0, -1, 1'b0, writes, dones);
            check($sformatf("vec%0d_writes", v), W'(writes), W'(vecs[v].exp_writes));
            check($sformatf("vec%0d_done_count", v), W'(dones), W'(1));
            check($sformatf("vec%0d_overflow", v), W'(o_overflow), W'(vecs[v].exp_ovf));
            check($sformatf("vec%0d_end_addr", v), W'(o_wr_addr),
                  W'(16'(vecs[v].base + 16'(vecs[v].exp_writes))));
            repeat (2) tick();
        end

        // num=0: o_done exactly three cycles after the start pulse
        i_start       = 1'b1;
        i_base_addr   = 16'h0A00;
        i_num_outputs = 16'd0;
        tick();
        i_start = 1'b0;
        tick();
        check("num0_no_done_early", W'(o_done), W'(1'b0));
        tick();
        check("num0_done_at_3", W'(o_done), W'(1'b1));
        check("num0_no_write", W'(o_wr_valid), W'(1'b0));
        repeat (2) tick();

        // issues while idle are ignored
        for (int k = 0; k < 6 + PIPE_LAT; k++) begin
            i_nfu3_issue = (k < 6);
            i_to_edram   = rand_word();
            i_wr_ready   = 1'b1;
            tick();
            check("idle_issue_no_valid", W'(o_wr_valid), W'(1'b0));
        end
        i_nfu3_issue = 1'b0;

        // second start during RUN is ignored
        run_job(16'h0500, 16'd2, 2, 1, 0, 1'b0, 2, 1'b0, writes, dones);
        check("restart_writes", W'(writes), W'(2));
        check("restart_end_addr", W'(o_wr_addr), W'(16'h0502));
        tick();

        // lane clamp / bit-exact data
        run_job(16'h0600, 16'd2, 2, 2, 0, 1'b0, -1, 1'b1, writes, dones);
        check("relu_writes", W'(writes), W'(2));
        tick();

        // reset in the middle of a drain drops valid immediately
        i_start       = 1'b1;
        i_base_addr   = 16'h0700;
        i_num_outputs = 16'd3;
        i_wr_ready    = 1'b0;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            i_nfu3_issue = (k < 3);
            i_to_edram   = rand_word();
            tick();
        end
        i_nfu3_issue = 1'b0;
        check("pre_reset_valid", W'(o_wr_valid), W'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_valid", W'(o_wr_valid), W'(1'b0));
        check("midreset_busy", W'(o_busy), W'(1'b0));
        check("midreset_addr", W'(o_wr_addr), W'(16'h0000));
        model_reset();
        @(negedge clk);
        rst_n      = 1'b1;
        i_wr_ready = 1'b1;
        repeat (3) tick();

        // randomized jobs against the model
        for (int j = 0; j < 25; j++) begin
            logic [15:0] nb;
            logic [15:0] nn;
            nb = 16'($urandom);
            nn = 16'($urandom_range(0, 8));
            run_job(nb, nn, int'(nn) + $urandom_range(0, 2), $urandom_range(1, 3),
                    $urandom_range(0, 12), 1'b1, -1, 1'b0, writes, dones);
            check("rand_done_count", W'(dones), W'(1));
            repeat ($urandom_range(1, 4)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
